// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for the 16-bit datapath: runs one instruction per accepted
// run strobe and owns every bus-drive and register-load enable.
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int IW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [IW-1:0]    instr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NREGS-1:0] r_in,
  output logic [NREGS-1:0] r_out,
  output logic             din_out,
  output logic             acc_out,
  output logic             a_enable,
  output logic             acc_enable,
  output logic             addsub,
  output logic             xor_ctrl
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100
  } opcode_e;

  // Only opcode, rx and ry are kept; instr[6:0] never reaches the outputs.
  localparam int IRW = 9;

  state_e          state_q, state_d;
  logic [IRW-1:0]  ir_q, ir_d;
  logic            err_q, err_d;

  opcode_e         op;
  logic [NREGS-1:0] rx_oh, ry_oh;
  logic            unused_instr_bits;

  assign unused_instr_bits = ^instr[IW-IRW-1:0];

  assign op    = opcode_e'(ir_q[8:6]);
  assign rx_oh = {{(NREGS-1){1'b0}}, 1'b1} << ir_q[5:3];
  assign ry_oh = {{(NREGS-1){1'b0}}, 1'b1} << ir_q[2:0];

  // NOTE: the instruction register is a plain control register, so it is reset like
  // the state; an abort must leave IR cleared, not holding the half-run instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge values.
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    err_d      = err_q;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    err        = err_q;
    r_in       = '0;
    r_out      = '0;
    din_out    = 1'b0;
    acc_out    = 1'b0;
    a_enable   = 1'b0;
    acc_enable = 1'b0;
    addsub     = 1'b0;
    xor_ctrl   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          ir_d    = instr[IW-1:IW-IRW];
          err_d   = 1'b0;
          state_d = S_T1;
        end
      end
      S_T1: begin
        case (op)
          OP_MV: begin
            r_out   = ry_oh;
            r_in    = rx_oh;
            state_d = S_DONE;
          end
          OP_MVI: begin
            din_out = 1'b1;
            r_in    = rx_oh;
            state_d = S_DONE;
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            r_out    = rx_oh;
            a_enable = 1'b1;
            state_d  = S_T2;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_T2: begin
        r_out      = ry_oh;
        acc_enable = 1'b1;
        addsub     = (op == OP_SUB);
        xor_ctrl   = (op == OP_XOR);
        state_d    = S_T3;
      end
      S_T3: begin
        acc_out = 1'b1;
        r_in    = rx_oh;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: per-cycle expected output vectors are queued
// when an instruction is issued and popped as the DUT steps through its states.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [15:0] instr = '0;
  logic        busy, done, err, din_out, acc_out, a_enable, acc_enable, addsub, xor_ctrl;
  logic [7:0]  r_in, r_out;

  int checks   = 0;
  int failures = 0;

  logic [24:0] exp_q[$];
  logic [24:0] obs;

  alu_sequencer #(.NREGS(8), .IW(16)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr),
    .busy(busy), .done(done), .err(err),
    .r_in(r_in), .r_out(r_out),
    .din_out(din_out), .acc_out(acc_out),
    .a_enable(a_enable), .acc_enable(acc_enable),
    .addsub(addsub), .xor_ctrl(xor_ctrl)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, err, r_in, r_out, din_out, acc_out,
                a_enable, acc_enable, addsub, xor_ctrl};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [24:0] pk(input logic b, input logic d, input logic e,
                                     input logic [7:0] ri, input logic [7:0] ro,
                                     input logic din, input logic acc, input logic aen,
                                     input logic accen, input logic as, input logic xc);
    return {b, d, e, ri, ro, din, acc, aen, accen, as, xc};
  endfunction

  // Reference model: expected outputs for each cycle from T1 through the IDLE cycle after DONE.
  task automatic push_expected(input logic [15:0] ins);
    logic [7:0] rxh, ryh;
    rxh = 8'd1 << ins[12:10];
    ryh = 8'd1 << ins[9:7];
    case (ins[15:13])
      3'b000: exp_q.push_back(pk(1, 0, 0, rxh, ryh, 0, 0, 0, 0, 0, 0));
      3'b001: exp_q.push_back(pk(1, 0, 0, rxh, 8'h00, 1, 0, 0, 0, 0, 0));
      3'b010, 3'b011, 3'b100: begin
        exp_q.push_back(pk(1, 0, 0, 8'h00, rxh, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(pk(1, 0, 0, 8'h00, ryh, 0, 0, 0, 1,
                           ins[15:13] == 3'b011, ins[15:13] == 3'b100));
        exp_q.push_back(pk(1, 0, 0, rxh, 8'h00, 0, 1, 0, 0, 0, 0));
      end
      default: exp_q.push_back(pk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    endcase
    if (ins[15:13] >= 3'b101) begin
      exp_q.push_back(pk(1, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(pk(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    end else begin
      exp_q.push_back(pk(1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(pk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // Issue one instruction from IDLE; run_mask bit i drives run high during cycle i after accept.
  task automatic run_instr(input logic [15:0] ins, input logic [7:0] run_mask, input string name);
    logic [24:0] e;
    int idx;
    run   = 1'b1;
    instr = ins;
    push_expected(ins);
    @(posedge clk);
    #1;
    idx = 0;
    while (exp_q.size() > 0) begin
      run   = run_mask[idx];
      instr = 16'($urandom);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s cycle k+%0d: got %b expected %b", name, idx + 1, obs, e);
      end
      idx++;
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
    run = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    run   = 1'b1;
    instr = 16'h0E80;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 25'd0) begin
        failures++;
        $display("FAIL reset_hold: got %b expected all zero", obs);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    run_instr(16'h0E80, 8'h00, "reset_release_mv_r3_r5");
  endtask

  task automatic test_mvi;
    run_instr(16'h3800, 8'h00, "mvi_r6");
  endtask

  task automatic test_sub;
    run_instr(16'h6500, 8'h00, "sub_r1_r2");
  endtask

  task automatic test_xor_illegal;
    run_instr(16'h8000, 8'h00, "xor_r0_r0");
    run_instr(16'hE07F, 8'h00, "illegal_111");
    run_instr(16'h0E80, 8'h00, "mv_clears_err");
  endtask

  task automatic test_back_to_back;
    run_instr(16'h4955, 8'h00, "add_r2_r2_junk_low");
    run_instr(16'h3C2A, 8'h00, "mvi_r7_back_to_back");
  endtask

  task automatic test_run_ignored;
    run_instr(16'h4500, 8'b0000_1010, "add_run_in_t2_done");
  endtask

  task automatic test_reset_mid;
    logic [24:0] e;
    run   = 1'b1;
    instr = 16'h4500;
    @(posedge clk);
    #1;
    run = 1'b0;
    e = pk(1, 0, 0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL abort_t1: got %b expected %b", obs, e);
    end
    @(posedge clk);
    #1;
    e = pk(1, 0, 0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL abort_t2: got %b expected %b", obs, e);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 25'd0) begin
      failures++;
      $display("FAIL abort_immediate: got %b expected all zero", obs);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 25'd0) begin
        failures++;
        $display("FAIL abort_no_done: got %b expected all zero", obs);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (dut.ir_q !== 9'd0) begin
      failures++;
      $display("FAIL abort_ir_cleared: got %h expected 0", dut.ir_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 25'd0) begin
      failures++;
      $display("FAIL abort_stays_idle: got %b expected all zero", obs);
    end
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_sub();
    test_xor_illegal();
    test_back_to_back();
    test_run_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
